// File: rtl/sram_host_ctrl.sv
// sram_host_ctrl: host-side controller for a serially loaded SRAM row array.
// Accepts one read or write request at a time. A write is shifted MSB-first
// into the SRAM SIPO and then committed with sram_w_en. A read asserts
// sram_r_en until sram_data_valid arrives or RD_TIMEOUT cycles elapse. Every
// request finishes with a one-cycle resp_valid pulse. All outputs are registered.
// Ports:
//   clk, arst                 clock, asynchronous active-high reset
//   req_valid/req_ready       host request handshake
//   req_we/req_addr/req_wdata request payload
//   resp_valid/resp_we/resp_err/resp_rdata  completion report
//   sram_serial_in/sram_shift/sram_w_en/sram_r_en/sram_addr  SRAM control
//   sram_data_valid/sram_data_out                            SRAM read return
module sram_host_ctrl #(
   parameter int unsigned ROWS       = 4,
   parameter int unsigned COLS       = 8,
   parameter int unsigned RD_TIMEOUT = 4
) (
   input  logic                                   clk,
   input  logic                                   arst,
   input  logic                                   req_valid,
   output logic                                   req_ready,
   input  logic                                   req_we,
   input  logic [((ROWS > 1) ? $clog2(ROWS) : 1)-1:0] req_addr,
   input  logic [COLS-1:0]                        req_wdata,
   output logic                                   resp_valid,
   output logic                                   resp_we,
   output logic                                   resp_err,
   output logic [COLS-1:0]                        resp_rdata,
   output logic                                   sram_serial_in,
   output logic                                   sram_shift,
   output logic                                   sram_w_en,
   output logic                                   sram_r_en,
   output logic [((ROWS > 1) ? $clog2(ROWS) : 1)-1:0] sram_addr,
   input  logic                                   sram_data_valid,
   input  logic [COLS-1:0]                        sram_data_out
);

   localparam int unsigned AW  = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam int unsigned AW1 = AW + 1;
   localparam int unsigned CW  = $clog2(COLS + 1);
   localparam int unsigned TW  = (RD_TIMEOUT > 1) ? $clog2(RD_TIMEOUT + 1) : 1;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      SHIFT = 3'd1,
      LOAD  = 3'd2,
      READ  = 3'd3,
      RESP  = 3'd4
   } state_t;

   state_t          state, state_n;
   logic [CW-1:0]   cnt, cnt_n;
   logic [TW-1:0]   tcnt, tcnt_n;
   logic            we_l, we_l_n;
   logic [COLS-1:0] sreg, sreg_n;

   logic            req_ready_n, resp_valid_n, resp_we_n, resp_err_n;
   logic [COLS-1:0] resp_rdata_n;
   logic            sram_serial_in_n, sram_shift_n, sram_w_en_n, sram_r_en_n;
   logic [AW-1:0]   sram_addr_n;

   logic            accept;
   logic            bad_addr;

   assign accept   = (state == IDLE) && req_valid && req_ready;
   assign bad_addr = {1'b0, req_addr} >= AW1'(ROWS);

   // State, datapath and registered outputs
   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         state          <= IDLE;
         cnt            <= '0;
         tcnt           <= '0;
         we_l           <= 1'b0;
         sreg           <= '0;
         req_ready      <= 1'b0;
         resp_valid     <= 1'b0;
         resp_we        <= 1'b0;
         resp_err       <= 1'b0;
         resp_rdata     <= '0;
         sram_serial_in <= 1'b0;
         sram_shift     <= 1'b0;
         sram_w_en      <= 1'b0;
         sram_r_en      <= 1'b0;
         sram_addr      <= '0;
      end else begin
         state          <= state_n;
         cnt            <= cnt_n;
         tcnt           <= tcnt_n;
         we_l           <= we_l_n;
         sreg           <= sreg_n;
         req_ready      <= req_ready_n;
         resp_valid     <= resp_valid_n;
         resp_we        <= resp_we_n;
         resp_err       <= resp_err_n;
         resp_rdata     <= resp_rdata_n;
         sram_serial_in <= sram_serial_in_n;
         sram_shift     <= sram_shift_n;
         sram_w_en      <= sram_w_en_n;
         sram_r_en      <= sram_r_en_n;
         sram_addr      <= sram_addr_n;
      end
   end

   // Next state and next output values; outputs describe the next cycle
   always_comb begin
      state_n          = state;
      cnt_n            = cnt;
      tcnt_n           = tcnt;
      we_l_n           = we_l;
      sreg_n           = sreg;
      req_ready_n      = 1'b0;
      resp_valid_n     = 1'b0;
      resp_we_n        = 1'b0;
      resp_err_n       = 1'b0;
      resp_rdata_n     = '0;
      sram_serial_in_n = 1'b0;
      sram_shift_n     = 1'b0;
      sram_w_en_n      = 1'b0;
      sram_r_en_n      = 1'b0;
      sram_addr_n      = sram_addr;

      case (state)
         IDLE: begin
            if (accept) begin
               we_l_n = req_we;
               sreg_n = req_wdata;
               if (bad_addr) begin
                  // No SRAM activity; sram_addr keeps its previous value
                  state_n      = RESP;
                  resp_valid_n = 1'b1;
                  resp_we_n    = req_we;
                  resp_err_n   = 1'b1;
               end else if (req_we) begin
                  // First serial bit goes out with the first shift; keep the rest
                  state_n          = SHIFT;
                  cnt_n            = '0;
                  sram_shift_n     = 1'b1;
                  sram_serial_in_n = req_wdata[COLS-1];
                  sreg_n           = req_wdata << 1;
                  sram_addr_n      = req_addr;
               end else begin
                  state_n     = READ;
                  tcnt_n      = '0;
                  sram_r_en_n = 1'b1;
                  sram_addr_n = req_addr;
               end
            end else begin
               req_ready_n = 1'b1;
            end
         end

         SHIFT: begin
            if (cnt == CW'(COLS - 1)) begin
               state_n     = LOAD;
               sram_w_en_n = 1'b1;
            end else begin
               cnt_n            = cnt + CW'(1);
               sram_shift_n     = 1'b1;
               sram_serial_in_n = sreg[COLS-1];
               sreg_n           = sreg << 1;
            end
         end

         LOAD: begin
            state_n      = RESP;
            resp_valid_n = 1'b1;
            resp_we_n    = we_l;
         end

         READ: begin
            if (sram_data_valid) begin
               state_n      = RESP;
               resp_valid_n = 1'b1;
               resp_rdata_n = sram_data_out;
            end else if (tcnt == TW'(RD_TIMEOUT - 1)) begin
               state_n      = RESP;
               resp_valid_n = 1'b1;
               resp_err_n   = 1'b1;
            end else begin
               tcnt_n      = tcnt + TW'(1);
               sram_r_en_n = 1'b1;
            end
         end

         RESP: begin
            state_n     = IDLE;
            req_ready_n = 1'b1;
         end

         default: begin
            state_n = IDLE;
         end
      endcase
   end

endmodule
